// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with bubble insertion, operand forwarding and bubble counter
module id_ex_stage #(
    parameter int CTRL_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              en,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [31:0]       id_pc,
    input  logic [31:0]       id_rdat1,
    input  logic [31:0]       id_rdat2,
    input  logic [31:0]       id_imm,
    input  logic [4:0]        id_rd,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [1:0]        forwarda_src,
    input  logic [1:0]        forwardb_src,
    input  logic [1:0]        memadd_forward,
    input  logic [31:0]       exmem_aluout,
    input  logic [31:0]       wb_data,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [31:0]       ex_imm,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [31:0]       ex_opa,
    output logic [31:0]       ex_opb,
    output logic [31:0]       ex_storedata,
    output logic [15:0]       bubble_cnt
);

    logic              valid_q, valid_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       rdat1_q, rdat1_d;
    logic [31:0]       rdat2_q, rdat2_d;
    logic [31:0]       imm_q, imm_d;
    logic [4:0]        rd_q, rd_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [15:0]       cnt_q, cnt_d;

    // Select 11 is reserved and falls back to the stored register value.
    function automatic logic [31:0] fwd_sel(input logic [1:0] sel, input logic [31:0] stored,
                                            input logic [31:0] alu, input logic [31:0] wb);
        case (sel)
            2'b01:   fwd_sel = alu;
            2'b10:   fwd_sel = wb;
            default: fwd_sel = stored;
        endcase
    endfunction

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        rdat1_d = rdat1_q;
        rdat2_d = rdat2_q;
        imm_d   = imm_q;
        rd_d    = rd_q;
        ctrl_d  = ctrl_q;
        cnt_d   = cnt_q;
        if (en) begin
            if (stall || flush) begin
                valid_d = 1'b0;
                pc_d    = '0;
                rdat1_d = '0;
                rdat2_d = '0;
                imm_d   = '0;
                rd_d    = '0;
                ctrl_d  = '0;
                if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end else begin
                valid_d = id_valid;
                pc_d    = id_pc;
                rdat1_d = id_rdat1;
                rdat2_d = id_rdat2;
                imm_d   = id_imm;
                rd_d    = id_rd;
                ctrl_d  = id_ctrl;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            rdat1_q <= '0;
            rdat2_q <= '0;
            imm_q   <= '0;
            rd_q    <= '0;
            ctrl_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            rdat1_q <= rdat1_d;
            rdat2_q <= rdat2_d;
            imm_q   <= imm_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_pc        = pc_q;
    assign ex_imm       = imm_q;
    assign ex_rd        = rd_q;
    assign ex_ctrl      = ctrl_q;
    assign bubble_cnt   = cnt_q;
    assign ex_opa       = fwd_sel(forwarda_src, rdat1_q, exmem_aluout, wb_data);
    assign ex_opb       = fwd_sel(forwardb_src, rdat2_q, exmem_aluout, wb_data);
    assign ex_storedata = fwd_sel(memadd_forward, rdat2_q, exmem_aluout, wb_data);

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard testbench for id_ex_stage
module tb_id_ex_stage;

    logic        CLK, RST, en, stall, flush, id_valid;
    logic [31:0] id_pc, id_rdat1, id_rdat2, id_imm;
    logic [4:0]  id_rd;
    logic [15:0] id_ctrl;
    logic [1:0]  forwarda_src, forwardb_src, memadd_forward;
    logic [31:0] exmem_aluout, wb_data;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_imm, ex_opa, ex_opb, ex_storedata;
    logic [4:0]  ex_rd;
    logic [15:0] ex_ctrl, bubble_cnt;

    id_ex_stage #(.CTRL_W(16)) dut (
        .CLK(CLK), .RST(RST), .en(en), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc), .id_rdat1(id_rdat1), .id_rdat2(id_rdat2),
        .id_imm(id_imm), .id_rd(id_rd), .id_ctrl(id_ctrl),
        .forwarda_src(forwarda_src), .forwardb_src(forwardb_src), .memadd_forward(memadd_forward),
        .exmem_aluout(exmem_aluout), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
        .ex_opa(ex_opa), .ex_opb(ex_opb), .ex_storedata(ex_storedata), .bubble_cnt(bubble_cnt)
    );

    typedef struct {
        string       name;
        logic        valid;
        logic [31:0] pc, imm;
        logic [4:0]  rd;
        logic [15:0] ctrl;
        logic [31:0] opa, opb, sd;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input string field, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%08h, required 0x%08h", name, field, act, exp);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, half a cycle away from state updates.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk(e.name, "ex_valid",     {31'd0, ex_valid}, {31'd0, e.valid});
                chk(e.name, "ex_pc",        ex_pc, e.pc);
                chk(e.name, "ex_imm",       ex_imm, e.imm);
                chk(e.name, "ex_rd",        {27'd0, ex_rd}, {27'd0, e.rd});
                chk(e.name, "ex_ctrl",      {16'd0, ex_ctrl}, {16'd0, e.ctrl});
                chk(e.name, "ex_opa",       ex_opa, e.opa);
                chk(e.name, "ex_opb",       ex_opb, e.opb);
                chk(e.name, "ex_storedata", ex_storedata, e.sd);
                chk(e.name, "bubble_cnt",   {16'd0, bubble_cnt}, {16'd0, e.cnt});
            end
        end
    end

    task automatic expect_out(input string name, input logic v, input logic [31:0] pc, input logic [31:0] imm,
                              input logic [4:0] rd, input logic [15:0] ctrl, input logic [31:0] opa,
                              input logic [31:0] opb, input logic [31:0] sd, input logic [15:0] cnt);
        exp_t e;
        e.name = name; e.valid = v; e.pc = pc; e.imm = imm; e.rd = rd; e.ctrl = ctrl;
        e.opa = opa; e.opb = opb; e.sd = sd; e.cnt = cnt;
        sb_q.push_back(e);
        @(negedge CLK);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2,
                          input logic [31:0] imm, input logic [4:0] rd, input logic [15:0] ctrl);
        id_valid = v; id_pc = pc; id_rdat1 = r1; id_rdat2 = r2; id_imm = imm; id_rd = rd; id_ctrl = ctrl;
    endtask

    task automatic set_fwd(input logic [1:0] a, input logic [1:0] b, input logic [1:0] m);
        forwarda_src = a; forwardb_src = b; memadd_forward = m;
    endtask

    initial begin
        RST = 1'b1; en = 1'b0; stall = 1'b0; flush = 1'b0;
        set_id(1'b1, 32'hDEAD_0000, 32'h1, 32'h2, 32'h3, 5'd9, 16'hFFFF);
        set_fwd(2'b00, 2'b00, 2'b00);
        exmem_aluout = 32'h99; wb_data = 32'h77;
        #3;
        expect_out("reset_sel00", 1'b0, 0, 0, 5'd0, 16'h0, 32'h0, 32'h0, 32'h0, 16'h0);
        set_fwd(2'b11, 2'b11, 2'b11);
        expect_out("reset_sel11", 1'b0, 0, 0, 5'd0, 16'h0, 32'h0, 32'h0, 32'h0, 16'h0);
        set_fwd(2'b01, 2'b10, 2'b01);
        expect_out("reset_fwd", 1'b0, 0, 0, 5'd0, 16'h0, 32'h99, 32'h77, 32'h99, 16'h0);

        RST = 1'b0; en = 1'b1;
        set_fwd(2'b00, 2'b00, 2'b00);
        set_id(1'b1, 32'h40, 32'h11, 32'h22, 32'h1234, 5'd5, 16'hA5A5);
        @(posedge CLK);
        expect_out("normal_load", 1'b1, 32'h40, 32'h1234, 5'd5, 16'hA5A5, 32'h11, 32'h22, 32'h22, 16'd0);

        stall = 1'b1;
        @(posedge CLK);
        expect_out("stall_bubble", 1'b0, 0, 0, 5'd0, 16'h0, 32'h0, 32'h0, 32'h0, 16'd1);
        stall = 1'b0; flush = 1'b1;
        @(posedge CLK);
        expect_out("flush_bubble", 1'b0, 0, 0, 5'd0, 16'h0, 32'h0, 32'h0, 32'h0, 16'd2);
        stall = 1'b1;
        @(posedge CLK);
        expect_out("stall_flush_once", 1'b0, 0, 0, 5'd0, 16'h0, 32'h0, 32'h0, 32'h0, 16'd3);

        stall = 1'b0; flush = 1'b0;
        set_id(1'b1, 32'h80, 32'h5, 32'h6, 32'h7, 5'd3, 16'h0F0F);
        @(posedge CLK);
        expect_out("load_80", 1'b1, 32'h80, 32'h7, 5'd3, 16'h0F0F, 32'h5, 32'h6, 32'h6, 16'd3);
        en = 1'b0; stall = 1'b1; flush = 1'b1;
        set_id(1'b0, 32'hCAFE, 32'hEE, 32'hFF, 32'h1, 5'd31, 16'h1111);
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            expect_out("hold", 1'b1, 32'h80, 32'h7, 5'd3, 16'h0F0F, 32'h5, 32'h6, 32'h6, 16'd3);
        end

        exmem_aluout = 32'hAA; wb_data = 32'hBB;
        set_fwd(2'b01, 2'b10, 2'b01);
        expect_out("fwd_a01_b10_m01", 1'b1, 32'h80, 32'h7, 5'd3, 16'h0F0F, 32'hAA, 32'hBB, 32'hAA, 16'd3);
        set_fwd(2'b11, 2'b00, 2'b10);
        expect_out("fwd_a11_b00_m10", 1'b1, 32'h80, 32'h7, 5'd3, 16'h0F0F, 32'h5, 32'h6, 32'hBB, 16'd3);
        set_fwd(2'b10, 2'b01, 2'b11);
        expect_out("fwd_a10_b01_m11", 1'b1, 32'h80, 32'h7, 5'd3, 16'h0F0F, 32'hBB, 32'hAA, 32'h6, 16'd3);

        en = 1'b1; stall = 1'b1; flush = 1'b0;
        set_fwd(2'b01, 2'b00, 2'b10);
        @(posedge CLK);
        expect_out("bubble_fwd", 1'b0, 0, 0, 5'd0, 16'h0, 32'hAA, 32'h0, 32'hBB, 16'd4);

        stall = 1'b0;
        set_fwd(2'b00, 2'b00, 2'b00);
        set_id(1'b1, 32'h100, 32'h31, 32'h32, 32'h33, 5'd7, 16'h00C3);
        @(posedge CLK);
        expect_out("load_100", 1'b1, 32'h100, 32'h33, 5'd7, 16'h00C3, 32'h31, 32'h32, 32'h32, 16'd4);
        en = 1'b0; stall = 1'b1;
        @(posedge CLK);
        #2;
        RST = 1'b1;
        expect_out("async_reset", 1'b0, 0, 0, 5'd0, 16'h0, 32'h0, 32'h0, 32'h0, 16'd0);

        RST = 1'b0; en = 1'b1; stall = 1'b0;
        set_id(1'b1, 32'h200, 32'h41, 32'h42, 32'h43, 5'd8, 16'h5A5A);
        @(posedge CLK);
        expect_out("resume_load", 1'b1, 32'h200, 32'h43, 5'd8, 16'h5A5A, 32'h41, 32'h42, 32'h42, 16'd0);

        stall = 1'b1;
        repeat (16'hFFFE) @(posedge CLK);
        expect_out("sat_preload", 1'b0, 0, 0, 5'd0, 16'h0, 32'h0, 32'h0, 32'h0, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            expect_out("saturate", 1'b0, 0, 0, 5'd0, 16'h0, 32'h0, 32'h0, 32'h0, 16'hFFFF);
        end

        @(negedge CLK);
        #1;
        chk("scoreboard", "pending", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter CTRL_W, default 16, width of the opaque decoded-control bundle.
REQ-002 SHALL have port CLK  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port RST  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port en  input  1  pipeline advance; 0 freezes all state (cache miss wait).
REQ-005 SHALL have port stall  input  1  hazard stall from hazard unit; insert bubble into EX.
REQ-006 SHALL have port flush  input  1  branch/jump squash of the ID instruction.
REQ-007 SHALL have ports id_valid 1, id_pc 32, id_rdat1 32, id_rdat2 32, id_imm 32, id_rd 5, id_ctrl CTRL_W, all inputs, the decode-stage fields.
REQ-008 SHALL have ports forwarda_src 2, forwardb_src 2, memadd_forward 2, all inputs: forwarding selects from hazard unit (00 none, 01 EX/MEM ALU result, 10 write-back data, 11 reserved).
REQ-009 SHALL have ports exmem_aluout 32 and wb_data 32, both inputs: forwarding sources.
REQ-010 SHALL have outputs ex_valid 1, ex_pc 32, ex_imm 32, ex_rd 5, ex_ctrl CTRL_W: registered EX-stage fields.
REQ-011 SHALL have outputs ex_opa 32, ex_opb 32, ex_storedata 32: forwarded operands.
REQ-012 SHALL have output bubble_cnt 16: count of bubbles inserted.

Function
REQ-013 SHALL register id_valid, id_pc, id_rdat1, id_rdat2, id_imm, id_rd, id_ctrl on a rising CLK edge when en=1, stall=0, flush=0 (one-cycle latency ID->EX).
REQ-014 SHALL hold every register, including bubble_cnt, when en=0, regardless of stall and flush.
REQ-015 SHALL, when en=1 and flush=1, load a bubble: ex_valid=0, ex_ctrl=0, ex_rd=0, ex_pc=0, ex_imm=0, stored rdat1/rdat2=0.
REQ-016 SHALL, when en=1, stall=1, flush=0, load the same bubble as REQ-015.
REQ-017 SHALL give priority RST > en=0 hold > flush > stall > normal load.
REQ-018 SHALL drive ex_opa combinationally from forwarda_src: 00 stored rdat1, 01 exmem_aluout, 10 wb_data, 11 stored rdat1.
REQ-019 SHALL drive ex_opb combinationally from forwardb_src with the same encoding applied to stored rdat2.
REQ-020 SHALL drive ex_storedata combinationally from memadd_forward with the same encoding applied to stored rdat2, independent of forwardb_src.
REQ-021 SHALL increment bubble_cnt by 1 each edge where en=1 and (stall=1 or flush=1); simultaneous stall and flush count once.
REQ-022 SHALL saturate bubble_cnt at 16'hFFFF; no wrap to 0.
REQ-023 SHALL not gate forwarding by ex_valid; a bubble with select 01 still outputs exmem_aluout.

Reset
REQ-024 SHALL on RST=1 immediately, without waiting for CLK, clear all registers: ex_valid=0, ex_pc=0, ex_imm=0, ex_rd=0, ex_ctrl=0, stored rdat1/rdat2=0, bubble_cnt=0.
REQ-025 SHALL, while RST=1, output ex_opa/ex_opb/ex_storedata=0 when their selects are 00 or 11.
REQ-026 SHALL resume normal loading on the first rising CLK edge after RST deasserts.
REQ-027 SHALL treat RST asserted mid-stall or mid-hold identically to REQ-024.

Verification
REQ-028 Normal load: en=1, id_valid=1, id_pc=0x00000040, id_rdat1=0x11, id_rdat2=0x22, selects 00 -> after one edge ex_valid=1, ex_pc=0x40, ex_opa=0x11, ex_opb=0x22, bubble_cnt=0.
REQ-029 Stall then flush: stall=1 one edge, then flush=1 one edge -> ex_valid=0, ex_ctrl=0 after each edge; bubble_cnt=2.
REQ-030 Hold: load pc=0x80, then en=0 with stall=1, flush=1 for 3 edges -> ex_pc stays 0x80, ex_valid=1, bubble_cnt unchanged.
REQ-031 Forwarding: stored rdat1=0x5, rdat2=0x6, exmem_aluout=0xAA, wb_data=0xBB; forwarda_src=01, forwardb_src=10, memadd_forward=01 -> ex_opa=0xAA, ex_opb=0xBB, ex_storedata=0xAA; forwarda_src=11 -> ex_opa=0x5.
REQ-032 Saturation: preload bubble_cnt to 0xFFFE via 0xFFFE stall edges, apply 3 more -> bubble_cnt=0xFFFF.
REQ-033 Async reset: assert RST between edges with ex_valid=1 -> ex_valid=0 and bubble_cnt=0 before the next CLK edge.
